mips_cpu_hilo_ctrl: RTL and testbench
=====================================

# mips_cpu_hilo_ctrl

Issuing side of the divider start/done handshake. Sits between the execute stage and `mips_cpu_div`. Accepts DIV/DIVU/MTHI/MTLO/MFHI/MFLO operations, drives the divider's start, sign and operands, waits for done, and writes HI/LO. Stalls the pipeline while a division is in flight, and recovers from a hung divider with a watchdog.

## Interface
- `TIMEOUT_CYCLES`, default 64: maximum number of WAIT cycles before the operation is aborted. Minimum legal value is 2.
- `clk` in 1: the single clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `op_valid` in 1: `op_code` and operands are valid this cycle.
- `op_code` in 3: 000 NOP, 001 DIV, 010 DIVU, 011 MTHI, 100 MTLO, 101 MFHI, 110 MFLO, 111 NOP.
- `op_rs` in 32: dividend, or the MTHI/MTLO source.
- `op_rt` in 32: divisor.
- `stall` out 1: operation not accepted; the pipeline holds it.
- `rd_data` out 32: MFHI/MFLO result.
- `rd_valid` out 1: `rd_data` is valid.
- `hi` out 32, `lo` out 32: architectural HI/LO registers.
- `timeout_err` out 1: sticky watchdog flag.
- `div_start` out 1: one-cycle start pulse to the divider.
- `div_sign` out 1: 1 for DIV, 0 for DIVU.
- `div_dividend` out 32, `div_divisor` out 32: registered operands, held stable for the whole operation.
- `div_reset` out 1: active-high reset to the divider.
- `div_done` in 1, `div_dbz` in 1, `div_quotient` in 32, `div_remainder` in 32: divider results.

## Operation
- **States:**
  - IDLE → ISSUE on an accepted DIV/DIVU.
  - ISSUE → WAIT unconditionally.
  - WAIT → IDLE on `div_done`, or on timeout.
- **Acceptance:**
  - An op is accepted on a rising edge where `op_valid`=1, `stall`=0 and `op_code` is not NOP.
  - `stall` is combinational: `stall` = (state≠IDLE) & `op_valid` & (`op_code` not NOP).
  - Every non-NOP op stalls while busy, including MT* and MF*.
- **DIV/DIVU accept:**
  - Latch `div_dividend`←`op_rs`, `div_divisor`←`op_rt`, `div_sign`←(`op_code`==DIV).
  - Enter ISSUE. `div_start`=1 only in ISSUE (registered, exactly one cycle).
- **WAIT:**
  - The divider clears `div_done` on the edge that samples start, so any `div_done`=1 seen in WAIT belongs to the current operation.
  - On `div_done`=1 with `div_dbz`=0: `hi`←`div_remainder`, `lo`←`div_quotient`, go to IDLE.
  - On `div_done`=1 with `div_dbz`=1: `hi`/`lo` unchanged, go to IDLE.
- **Watchdog:**
  - Counter cleared on entering WAIT and incremented each WAIT cycle.
  - If WAIT cycle number `TIMEOUT_CYCLES` has no `div_done`: a registered `div_reset` pulse of one cycle, `timeout_err`←1, `hi`/`lo` unchanged, go to IDLE.
  - `timeout_err` clears only on reset.
- **Divider reset:** `div_reset` = (`reset`==0) | timeout pulse, so the divider is held in reset while this block is.
- **MTHI/MTLO:** `hi`/`lo`←`op_rs` on the accepting edge. State stays IDLE.
- **MFHI/MFLO:**
  - On the accepting edge, `rd_data`←`hi`/`lo` (the value before that edge) and `rd_valid`←1 for one cycle.
  - `rd_data` holds its value otherwise.
- **Reset (`reset`=0, asynchronous):**
  - State IDLE, counter 0.
  - `hi`, `lo`, `rd_data`, `div_dividend`, `div_divisor` = 0.
  - `rd_valid`, `div_start`, `div_sign`, `timeout_err` = 0.
- **Reset mid-operation:** the operation is abandoned, no HI/LO write occurs, and the divider is reset through `div_reset`.

## Timing
- **DIV accepted at edge E:**
  - ISSUE during cycle E..E+1 (`div_start` high).
  - WAIT from edge E+1.
  - If `div_done` is first seen high in the cycle ending at edge D: HI/LO update at D, state IDLE at D, and `stall` drops after D.
- **Follow-on MF*:** an MF* op stalled behind a division is accepted at edge D+1. It returns the new value, with `rd_valid` high from D+1 to D+2.
- **Back-to-back MT*/MF*:** no bubble. MTLO at edge k, then MFLO at edge k+1, returns the written value.
- **Timeout abort:** occurs at the edge ending WAIT cycle `TIMEOUT_CYCLES`. `div_reset` is high for the following cycle.
- **Simultaneous timeout and done:** if `div_done` arrives in the timeout cycle, done wins. The result is written and no timeout is flagged.
- **Operand stability:** `op_rs`/`op_rt` changes after acceptance have no effect on the division.

## Test plan
- **Signed divide:** DIV `op_rs`=0xFFFFFFF9, `op_rt`=2, divider model returns q=0xFFFFFFFD, r=0xFFFFFFFF. Required: `div_sign`=1, a single `div_start` pulse, then `hi`=0xFFFFFFFF and `lo`=0xFFFFFFFD after done.
- **Unsigned divide with stalled reads:** DIVU 100/7 followed by MFHI, then MFLO. Required: `stall` high until the cycle after done, `rd_data`=2 then 14, each with a one-cycle `rd_valid`.
- **Divide by zero:** MTHI 0x1234, MTLO 0x5678, DIV x/0, divider returns `div_dbz`=1 with done. Required: `hi`=0x1234 and `lo`=0x5678 unchanged, `timeout_err`=0.
- **Watchdog:** DIV with `div_done` held 0 and `TIMEOUT_CYCLES`=64. Required: a one-cycle `div_reset` pulse after the 64th WAIT cycle, `timeout_err`=1, `stall` released, HI/LO unchanged. A following DIVU completes normally.
- **Reset mid-operation:** `reset` low in WAIT cycle 10. Required: all outputs at reset values immediately, `div_reset` high while `reset`=0, and the next DIVU 9/3 gives `lo`=3, `hi`=0.
- **MT/MF forwarding:** MTLO 0xDEADBEEF immediately followed by MFLO. Required: no stall, `rd_data`=0xDEADBEEF one cycle after MFLO is accepted.

Source files
------------

// File: rtl/mips_cpu_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// mips_cpu_hilo_ctrl : HI/LO registers and divider start/done issue control
// Revision 1.0
// ============================================================================
module mips_cpu_hilo_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_rs,
  input  logic [31:0] op_rt,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        timeout_err,
  output logic        div_start,
  output logic        div_sign,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_reset,
  input  logic        div_done,
  input  logic        div_dbz,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] OP_NOP0 = 3'b000;
  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_DIVU = 3'b010;
  localparam logic [2:0] OP_MTHI = 3'b011;
  localparam logic [2:0] OP_MTLO = 3'b100;
  localparam logic [2:0] OP_MFHI = 3'b101;
  localparam logic [2:0] OP_MFLO = 3'b110;
  localparam logic [2:0] OP_NOP7 = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        err_q, err_d;
  logic        start_q, start_d;
  logic        sign_q, sign_d;
  logic [31:0] dividend_q, dividend_d;
  logic [31:0] divisor_q, divisor_d;
  logic        wdog_q, wdog_d;

  logic        is_op;
  logic        busy;
  logic        accept;

  always_comb begin
    is_op      = op_valid & (op_code != OP_NOP0) & (op_code != OP_NOP7);
    busy       = (state_q != ST_IDLE);
    accept     = ~busy & is_op;
    stall      = busy & is_op;

    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = err_q;
    start_d    = 1'b0;
    sign_d     = sign_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    wdog_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op_code)
            OP_DIV, OP_DIVU: begin
              dividend_d = op_rs;
              divisor_d  = op_rt;
              sign_d     = (op_code == OP_DIV);
              start_d    = 1'b1;
              state_d    = ST_ISSUE;
            end
            OP_MTHI: hi_d = op_rs;
            OP_MTLO: lo_d = op_rs;
            OP_MFHI: begin
              rd_data_d  = hi_q;
              rd_valid_d = 1'b1;
            end
            OP_MFLO: begin
              rd_data_d  = lo_q;
              rd_valid_d = 1'b1;
            end
            default: ;
          endcase
        end
      end

      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // done is checked first so a result in the final watchdog cycle still lands
        if (div_done) begin
          if (!div_dbz) begin
            hi_d = div_remainder;
            lo_d = div_quotient;
          end
          state_d = ST_IDLE;
        end else if (cnt_q == LAST_CNT) begin
          wdog_d  = 1'b1;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
      sign_q     <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      wdog_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      start_q    <= start_d;
      sign_q     <= sign_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      wdog_q     <= wdog_d;
    end
  end

  // The divider follows this block's reset as well as the watchdog pulse
  assign div_reset    = ~reset | wdog_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign hi           = hi_q;
  assign lo           = lo_q;
  assign timeout_err  = err_q;
  assign div_start    = start_q;
  assign div_sign     = sign_q;
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mips_cpu_hilo_ctrl : randomized bench with a divider model and reference
// Revision 1.0
// ============================================================================
module tb_mips_cpu_hilo_ctrl;

  localparam int T = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op_code = 3'd0;
  logic [31:0] op_rs = 32'd0;
  logic [31:0] op_rt = 32'd0;
  logic        stall, rd_valid, timeout_err, div_start, div_sign, div_reset;
  logic [31:0] rd_data, hi, lo, div_dividend, div_divisor;
  logic        div_done = 1'b0;
  logic        div_dbz = 1'b0;
  logic [31:0] div_quotient = 32'd0;
  logic [31:0] div_remainder = 32'd0;

  always #5 clk = ~clk;

  mips_cpu_hilo_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .op_rs(op_rs), .op_rt(op_rt), .stall(stall), .rd_data(rd_data),
    .rd_valid(rd_valid), .hi(hi), .lo(lo), .timeout_err(timeout_err),
    .div_start(div_start), .div_sign(div_sign), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_reset(div_reset), .div_done(div_done),
    .div_dbz(div_dbz), .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Reference model: timeline of a division counted in cycles since acceptance
  logic [31:0] m_hi, m_lo, m_rd, m_dvd, m_dvs;
  logic        m_rdv, m_err, m_sign, m_pulse;
  int          m_since;
  bit          m_acc;

  function automatic bit is_real_op(input logic v, input logic [2:0] c);
    return v && (c != 3'd0) && (c != 3'd7);
  endfunction

  task automatic model_reset();
    m_hi = 0; m_lo = 0; m_rd = 0; m_dvd = 0; m_dvs = 0;
    m_rdv = 0; m_err = 0; m_sign = 0; m_pulse = 0;
    m_since = 0; m_acc = 0;
  endtask

  task automatic model_edge();
    m_acc = 0;
    if (!reset) begin
      model_reset();
      return;
    end
    m_rdv = 0;
    m_pulse = 0;
    if (m_since > 0) begin
      if (m_since >= 2 && div_done) begin
        if (!div_dbz) begin
          m_hi = div_remainder;
          m_lo = div_quotient;
        end
        m_since = 0;
      end else if (m_since - 1 == T) begin
        m_pulse = 1; m_err = 1; m_since = 0;
      end else begin
        m_since++;
      end
    end else if (is_real_op(op_valid, op_code)) begin
      m_acc = 1;
      case (op_code)
        3'd1, 3'd2: begin
          m_dvd = op_rs; m_dvs = op_rt; m_sign = (op_code == 3'd1); m_since = 1;
        end
        3'd3: m_hi = op_rs;
        3'd4: m_lo = op_rs;
        3'd5: begin m_rd = m_hi; m_rdv = 1; end
        3'd6: begin m_rd = m_lo; m_rdv = 1; end
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs();
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    check("rd_data", rd_data, m_rd);
    check("rd_valid", rd_valid, m_rdv);
    check("timeout_err", timeout_err, m_err);
    check("div_start", div_start, (m_since == 1));
    check("div_sign", div_sign, m_sign);
    check("div_dividend", div_dividend, m_dvd);
    check("div_divisor", div_divisor, m_dvs);
    check("div_reset", div_reset, (!reset || m_pulse));
  endtask

  // Divider model: responds to the DUT's start pulse after a chosen latency
  int          env_cnt = 0;
  int          force_lat = 0;
  int          n_start = 0;
  int          n_divrst = 0;
  logic [31:0] env_q, env_r;
  logic        env_dbz;

  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 100000;
    if (r == 1) return T;
    if (r == 2) return T + 1;
    return $urandom_range(1, 6);
  endfunction

  task automatic env_update();
    if (div_reset) n_divrst++;
    div_done = 0;
    div_dbz = 0;
    div_quotient = $urandom;
    div_remainder = $urandom;
    if (!reset || div_reset) begin
      env_cnt = 0;
      return;
    end
    if (div_start) begin
      n_start++;
      env_cnt = (force_lat > 0) ? force_lat : pick_lat();
      env_dbz = (div_divisor == 0);
      if (!env_dbz) begin
        if (div_sign && div_dividend == 32'h8000_0000 && div_divisor == 32'hFFFF_FFFF) begin
          env_q = 32'h8000_0000; env_r = 0;
        end else if (div_sign) begin
          env_q = $signed(div_dividend) / $signed(div_divisor);
          env_r = $signed(div_dividend) % $signed(div_divisor);
        end else begin
          env_q = div_dividend / div_divisor;
          env_r = div_dividend % div_divisor;
        end
      end
    end else if (env_cnt > 0) begin
      env_cnt--;
      if (env_cnt == 0) begin
        div_done = 1;
        div_dbz = env_dbz;
        if (!env_dbz) begin
          div_quotient = env_q;
          div_remainder = env_r;
        end
      end
    end
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge
  task automatic step(input logic v, input logic [2:0] c, input logic [31:0] rs, input logic [31:0] rt);
    op_valid = v; op_code = c; op_rs = rs; op_rt = rt;
    #1;
    check("stall", stall, (m_since > 0) && is_real_op(v, c));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    env_update();
  endtask

  task automatic issue(input logic [2:0] c, input logic [31:0] rs, input logic [31:0] rt);
    for (int i = 0; i < 300; i++) begin
      step(1, c, rs, rt);
      if (m_acc) return;
    end
    bound_fail("issue");
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (m_since == 0) return;
      step(0, 3'd0, $urandom, $urandom);
    end
    bound_fail("drain");
  endtask

  int s0;

  initial begin
    model_reset();
    #2 reset = 0;
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_div_start", div_start, 0);
    check("rst_div_sign", div_sign, 0);
    check("rst_div_dividend", div_dividend, 0);
    check("rst_div_divisor", div_divisor, 0);
    check("rst_div_reset", div_reset, 1);
    check("rst_stall", stall, 0);
    reset = 1;
    step(0, 3'd0, 0, 0);
    step(0, 3'd0, 0, 0);

    // Signed divide
    force_lat = 3;
    s0 = n_start;
    issue(3'd1, 32'hFFFF_FFF9, 32'd2);
    check("sdiv_start", div_start, 1);
    check("sdiv_sign", div_sign, 1);
    drain();
    check("sdiv_nstart", n_start - s0, 1);
    check("sdiv_hi", hi, 32'hFFFF_FFFF);
    check("sdiv_lo", lo, 32'hFFFF_FFFD);

    // Unsigned divide followed by stalled reads
    force_lat = 5;
    issue(3'd2, 32'd100, 32'd7);
    issue(3'd5, 32'd0, 32'd0);
    check("mfhi_data", rd_data, 32'd2);
    check("mfhi_valid", rd_valid, 1);
    issue(3'd6, 32'd0, 32'd0);
    check("mflo_data", rd_data, 32'd14);
    check("mflo_valid", rd_valid, 1);
    step(0, 3'd0, 0, 0);
    check("rd_hold_valid", rd_valid, 0);
    check("rd_hold_data", rd_data, 32'd14);

    // Divide by zero leaves HI/LO alone
    issue(3'd3, 32'h1234, 0);
    issue(3'd4, 32'h5678, 0);
    force_lat = 2;
    issue(3'd1, 32'h55, 0);
    drain();
    check("dbz_hi", hi, 32'h1234);
    check("dbz_lo", lo, 32'h5678);
    check("dbz_err", timeout_err, 0);

    // Watchdog on a hung divider
    force_lat = 100000;
    s0 = n_divrst;
    issue(3'd1, 32'd77, 32'd5);
    drain();
    check("wd_div_reset", div_reset, 1);
    step(0, 3'd0, 0, 0);
    check("wd_err", timeout_err, 1);
    check("wd_pulse_len", n_divrst - s0, 1);
    check("wd_hi", hi, 32'h1234);
    check("wd_lo", lo, 32'h5678);
    force_lat = 4;
    issue(3'd2, 32'd1000, 32'd10);
    drain();
    check("wd_next_lo", lo, 32'd100);
    check("wd_next_hi", hi, 32'd0);

    // Reset in WAIT cycle 10
    force_lat = 100000;
    issue(3'd1, 32'd5, 32'd3);
    for (int i = 0; i < 40 && m_since < 11; i++) step(0, 3'd0, 0, 0);
    check("mid_wait_cycle", m_since, 11);
    reset = 0;
    model_reset();
    #1;
    check("mid_hi", hi, 0);
    check("mid_lo", lo, 0);
    check("mid_rd_data", rd_data, 0);
    check("mid_rd_valid", rd_valid, 0);
    check("mid_err", timeout_err, 0);
    check("mid_div_start", div_start, 0);
    check("mid_div_sign", div_sign, 0);
    check("mid_dividend", div_dividend, 0);
    check("mid_divisor", div_divisor, 0);
    check("mid_div_reset", div_reset, 1);
    check("mid_stall", stall, 0);
    step(0, 3'd0, 0, 0);
    step(0, 3'd0, 0, 0);
    reset = 1;
    force_lat = 3;
    issue(3'd2, 32'd9, 32'd3);
    drain();
    check("post_rst_lo", lo, 32'd3);
    check("post_rst_hi", hi, 32'd0);

    // MTLO then MFLO back to back
    issue(3'd4, 32'hDEAD_BEEF, 0);
    op_valid = 1; op_code = 3'd6;
    #1;
    check("fwd_no_stall", stall, 0);
    s0 = 0;
    step(1, 3'd6, 0, 0);
    check("fwd_data", rd_data, 32'hDEAD_BEEF);
    check("fwd_valid", rd_valid, 1);

    // Randomized traffic
    force_lat = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rs, rt;
      logic        v;
      logic [2:0]  c;
      rs = $urandom;
      case ($urandom_range(0, 9))
        0: rt = 0;
        1, 2: rt = $urandom_range(1, 20);
        3: begin rt = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 0) rs = 32'h8000_0000; end
        default: rt = $urandom;
      endcase
      v = ($urandom_range(0, 9) < 7);
      c = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) begin
        reset = 0;
        model_reset();
        step(v, c, rs, rt);
        reset = 1;
      end else begin
        step(v, c, rs, rt);
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
